// File: rtl/fm0_pkg.sv
// fm0_pkg: decoder state encoding and CRC-16/CCITT constants shared by the FM0 decoder files.
package fm0_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAL,
        MID,
        DATA,
        HALF0,
        DONE,
        ERR
    } fm0_state_e;

    localparam logic [15:0] CRC_POLY    = 16'h1021;
    localparam logic [15:0] CRC_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;

    // One MSB-first CRC-16/CCITT shift for a single decoded bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic [15:0] shifted;
        shifted = {crc[14:0], 1'b0};
        return (crc[15] ^ din) ? (shifted ^ CRC_POLY) : shifted;
    endfunction

endpackage

// File: rtl/fm0_edge_sync.sv
// fm0_edge_sync: tag_data synchroniser, transition detector and saturating
// interval counter (cycles since the previous transition).
module fm0_edge_sync
#(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tag_i,
    output logic             edge_o,
    output logic [CNT_W-1:0] ivl_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       ivl_q;
    logic [CNT_W-1:0]       ivl_d;

    assign edge_o = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign ivl_o  = ivl_q;

    // On an edge ivl_o holds the full length of the interval that just ended.
    always_comb begin
        ivl_d = ivl_q;
        if (edge_o) begin
            ivl_d = CNT_W'(1);
        end else if (~&ivl_q) begin
            ivl_d = ivl_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            ivl_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tag_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            ivl_q  <= ivl_d;
        end
    end

endmodule

// File: rtl/fm0_sync_decoder.sv
// fm0_sync_decoder: self-calibrating FM0 decoder on base_clk with per-bit strobe.
// Define FM0_CRC16_EN to add the crc_ok output and the CRC-16 residue check.
module fm0_sync_decoder
    import fm0_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int BITCNT_W    = 7,
    parameter int MIN_HALF    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                base_clk,
    input  logic                rst_n,
    input  logic                dec_en,
    input  logic                tag_data,
    input  logic [BITCNT_W-1:0] frame_len,
    output logic                fm0_start,
    output logic                fm0_data,
    output logic                fm0_valid,
    output logic [CNT_W-1:0]    fm0_bltc,
    output logic                fm0_done,
    output logic                fm0_err,
    output logic [BITCNT_W-1:0] bit_cnt
`ifdef FM0_CRC16_EN
    ,
    output logic                crc_ok
`endif
);

    localparam logic [CNT_W-1:0] MIN_HALF_C = CNT_W'(MIN_HALF);

    logic                edge_w;
    logic [CNT_W-1:0]    ivl_w;
    logic [CNT_W:0]      ivl_x;
    logic [CNT_W+1:0]    half_x;
    logic [CNT_W:0]      pivot_w;
    logic [CNT_W:0]      limit_w;
    logic                is_short;
    logic                is_over;
    logic                bit_full;

    fm0_state_e          state_q;
    logic                armed_q;
    logic                start_q;
    logic                valid_q;
    logic                data_q;
    logic                done_q;
    logic                err_q;
    logic [CNT_W-1:0]    half_q;
    logic [BITCNT_W-1:0] flen_q;
    logic [BITCNT_W-1:0] bit_cnt_q;
`ifdef FM0_CRC16_EN
    logic [15:0]         crc_q;
    logic                crc_ok_q;
`endif

    fm0_edge_sync #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk_i  (base_clk),
        .rst_ni (rst_n),
        .tag_i  (tag_data),
        .edge_o (edge_w),
        .ivl_o  (ivl_w)
    );

    // Thresholds beyond the CNT_W+1 range clamp to all-ones instead of wrapping.
    function automatic logic [CNT_W:0] sat_thr(input logic [CNT_W+1:0] v);
        return v[CNT_W+1] ? {(CNT_W+1){1'b1}} : v[CNT_W:0];
    endfunction

    assign half_x   = {2'b00, half_q};
    assign pivot_w  = sat_thr(half_x + (half_x >> 1));
    assign limit_w  = sat_thr((half_x << 1) + (half_x >> 1));
    assign ivl_x    = {1'b0, ivl_w};
    assign is_short = ivl_x < pivot_w;
    assign is_over  = ivl_x > limit_w;
    assign bit_full = bit_cnt_q == flen_q;

    always_ff @(posedge base_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            armed_q   <= 1'b1;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            half_q    <= '0;
            flen_q    <= '0;
            bit_cnt_q <= '0;
`ifdef FM0_CRC16_EN
            crc_q     <= CRC_PRESET;
            crc_ok_q  <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (!dec_en) begin
                state_q   <= IDLE;
                armed_q   <= 1'b1;
                bit_cnt_q <= '0;
                err_q     <= 1'b0;
`ifdef FM0_CRC16_EN
                crc_ok_q  <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (armed_q && edge_w) begin
                            start_q   <= 1'b1;
                            flen_q    <= frame_len;
                            bit_cnt_q <= '0;
                            state_q   <= CAL;
`ifdef FM0_CRC16_EN
                            crc_q     <= CRC_PRESET;
                            crc_ok_q  <= 1'b0;
`endif
                        end
                    end
                    CAL: begin
                        if (edge_w) begin
                            half_q <= ivl_w;
                            if (ivl_w < MIN_HALF_C) begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end else begin
                                state_q <= MID;
                            end
                        end
                    end
                    MID: begin
                        if (edge_w) begin
                            if (is_short) begin
                                state_q <= DATA;
                            end else begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end
                        end else if (is_over) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                    // A full-length interval is a 1; a short one is the first half of a 0.
                    DATA: begin
                        if (edge_w) begin
                            if (is_short) begin
                                state_q <= HALF0;
                            end else if (is_over || bit_full) begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end else begin
                                valid_q   <= 1'b1;
                                data_q    <= 1'b1;
                                bit_cnt_q <= bit_cnt_q + BITCNT_W'(1);
`ifdef FM0_CRC16_EN
                                crc_q     <= crc16_step(crc_q, 1'b1);
`endif
                            end
                        end else if (is_over) begin
                            if (bit_full) begin
                                state_q  <= DONE;
                                done_q   <= 1'b1;
`ifdef FM0_CRC16_EN
                                crc_ok_q <= crc_q == CRC_RESIDUE;
`endif
                            end else begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end
                        end
                    end
                    HALF0: begin
                        if (edge_w) begin
                            if (!is_short || bit_full) begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end else begin
                                state_q   <= DATA;
                                valid_q   <= 1'b1;
                                data_q    <= 1'b0;
                                bit_cnt_q <= bit_cnt_q + BITCNT_W'(1);
`ifdef FM0_CRC16_EN
                                crc_q     <= crc16_step(crc_q, 1'b0);
`endif
                            end
                        end else if (is_over) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                    // Completed frames must see dec_en drop before the next start.
                    DONE: begin
                        state_q <= IDLE;
                        armed_q <= 1'b0;
                    end
                    ERR: begin
                        state_q <= ERR;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign fm0_start = start_q;
    assign fm0_data  = data_q;
    assign fm0_valid = valid_q;
    assign fm0_bltc  = half_q;
    assign fm0_done  = done_q;
    assign fm0_err   = err_q;
    assign bit_cnt   = bit_cnt_q;
`ifdef FM0_CRC16_EN
    assign crc_ok    = crc_ok_q;
`endif

endmodule

// File: tb/tb_fm0_sync_decoder.sv
// tb_fm0_sync_decoder: randomized FM0 frames checked by a bit scoreboard and frame-outcome model.
// Define FM0_CRC16_EN to also exercise crc_ok.
`timescale 1ns/1ps
module tb_fm0_sync_decoder;

    localparam int CNT_W       = 8;
    localparam int BITCNT_W    = 7;
    localparam int MIN_HALF    = 4;
    localparam int SYNC_STAGES = 2;

    logic                base_clk = 1'b0;
    logic                rst_n    = 1'b0;
    logic                dec_en   = 1'b0;
    logic                tag_data = 1'b0;
    logic [BITCNT_W-1:0] frame_len = '0;
    logic                fm0_start;
    logic                fm0_data;
    logic                fm0_valid;
    logic [CNT_W-1:0]    fm0_bltc;
    logic                fm0_done;
    logic                fm0_err;
    logic [BITCNT_W-1:0] bit_cnt;
`ifdef FM0_CRC16_EN
    logic                crc_ok;
`endif

    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   start_cnt = 0;
    int   done_cyc = 0;
    int   last_tog = 0;
    int   prev_bltc = 0;
    logic exp_bits[$];
    int   iv[$];
    logic mon_exp;

    fm0_sync_decoder #(
        .CNT_W       (CNT_W),
        .BITCNT_W    (BITCNT_W),
        .MIN_HALF    (MIN_HALF),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .base_clk  (base_clk),
        .rst_n     (rst_n),
        .dec_en    (dec_en),
        .tag_data  (tag_data),
        .frame_len (frame_len),
        .fm0_start (fm0_start),
        .fm0_data  (fm0_data),
        .fm0_valid (fm0_valid),
        .fm0_bltc  (fm0_bltc),
        .fm0_done  (fm0_done),
        .fm0_err   (fm0_err),
        .bit_cnt   (bit_cnt)
`ifdef FM0_CRC16_EN
        ,
        .crc_ok    (crc_ok)
`endif
    );

    always #5 base_clk = ~base_clk;
    always @(posedge base_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe pops the next expected bit from the scoreboard.
    always @(negedge base_clk) begin
        if (rst_n) begin
            if (fm0_valid === 1'b1) begin
                n_vec++;
                if (exp_bits.size() == 0) begin
                    n_mis++;
                    $display("FAIL strobe: got unexpected bit %0b, expected no strobe", fm0_data);
                end else begin
                    mon_exp = exp_bits.pop_front();
                    if (fm0_data !== mon_exp) begin
                        n_mis++;
                        $display("FAIL strobe_data: got %0b, expected %0b", fm0_data, mon_exp);
                    end
                end
            end
            if (fm0_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (fm0_start === 1'b1) start_cnt++;
        end
    end

    function automatic int jit(input bit en);
        return en ? (int'($urandom_range(0, 2)) - 1) : 0;
    endfunction

    function automatic logic [15:0] ref_crc(input logic [15:0] payload);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ payload[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // Pulse dec_en low (checking the clear), then re-arm with a new frame length.
    task automatic arm(input int flen);
        dec_en = 1'b0;
        repeat (2) @(negedge base_clk);
        check("idle_bit_cnt", bit_cnt, 0);
        check("idle_err", fm0_err, 0);
        check("bltc_kept", fm0_bltc, prev_bltc);
        dec_en    = 1'b1;
        frame_len = BITCNT_W'(flen);
        done_cnt  = 0;
        start_cnt = 0;
        @(negedge base_clk);
    endtask

    // First toggle starts the calibration symbol; frame_len is scrambled once latched.
    task automatic drive();
        tag_data = ~tag_data;
        last_tog = cyc;
        for (int i = 0; i < iv.size(); i++) begin
            repeat (iv[i]) @(negedge base_clk);
            tag_data = ~tag_data;
            last_tog = cyc;
            if (i == 0) frame_len = ~frame_len;
        end
    endtask

    task automatic run_ivls(input string name, input bit exp_done, input bit exp_err,
                            input int exp_cnt, input int exp_bltc, input int lim);
        int k;
        int lat;
        drive();
        k = 0;
        while (k < 400 && done_cnt == 0 && fm0_err !== 1'b1) begin
            @(negedge base_clk);
            k++;
        end
        repeat (4) @(negedge base_clk);
        check({name, "_start"}, start_cnt, 1);
        check({name, "_done"}, done_cnt, exp_done);
        check({name, "_err"}, fm0_err, exp_err);
        check({name, "_bit_cnt"}, bit_cnt, exp_cnt);
        check({name, "_bltc"}, fm0_bltc, exp_bltc);
        check({name, "_bits_left"}, exp_bits.size(), 0);
        exp_bits.delete();
        if (exp_done && done_cnt == 1) begin
            lat = done_cyc - last_tog;
            n_vec++;
            if (lat < lim + 2 || lat > lim + 6) begin
                n_mis++;
                $display("FAIL %s_done_latency: got %0d cycles, expected %0d..%0d", name, lat, lim + 2, lim + 6);
            end
        end
        prev_bltc = exp_bltc;
    endtask

    // Reference: symbol lengths from FM0 rules; the decoder should deliver at most frame_len bits.
    task automatic run_frame(input string name, input int half, input int flen,
                             input int nbits, input logic [63:0] bits, input bit jt);
        int ncnt;
        logic b;
        arm(flen);
        iv.delete();
        iv.push_back(half);
        iv.push_back(half + jit(jt));
        for (int i = 0; i < nbits; i++) begin
            b = bits[nbits-1-i];
            if (b) begin
                iv.push_back(2 * half + jit(jt));
            end else begin
                iv.push_back(half + jit(jt));
                iv.push_back(half + jit(jt));
            end
            if (i < flen) exp_bits.push_back(b);
        end
        ncnt = (nbits < flen) ? nbits : flen;
        run_ivls(name, nbits == flen, nbits != flen, ncnt, half, 2 * half + half / 2);
    endtask

`ifdef FM0_CRC16_EN
    task automatic crc_frame(input string name, input logic [15:0] payload,
                             input logic [15:0] crc_src, input bit exp_ok);
        logic [15:0] c;
        c = ref_crc(crc_src);
        run_frame(name, 8, 32, 32, {32'h0, payload, ~c}, 1'b0);
        check({name, "_crc_ok"}, crc_ok, exp_ok);
    endtask
`endif

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int half;
        int flen;
        int nbits;
        int mode;
        int k;
        repeat (3) @(negedge base_clk);
        check("rst_start", fm0_start, 0);
        check("rst_valid", fm0_valid, 0);
        check("rst_data", fm0_data, 0);
        check("rst_done", fm0_done, 0);
        check("rst_err", fm0_err, 0);
        check("rst_bltc", fm0_bltc, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge base_clk);

        run_frame("basic", 10, 8, 8, 64'hB2, 1'b0);

        arm(8);
        exp_bits.push_back(1'b1);
        iv = {10, 10, 20, 6, 18};
        run_ivls("violation", 1'b0, 1'b1, 1, 10, 25);

        arm(8);
        iv = {3, 3, 6, 3, 3};
        run_ivls("cal_fast", 1'b0, 1'b1, 0, 3, 7);

        run_frame("truncated", 10, 8, 5, 64'h16, 1'b0);
        run_frame("flen_zero", 7, 0, 0, 64'h0, 1'b0);
        run_frame("overflow", 9, 4, 6, 64'h2D, 1'b0);

        arm(8);
        iv = {10, 10, 20, 10, 10, 20};
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b0);
        exp_bits.push_back(1'b1);
        drive();
        k = 0;
        while (k < 50 && bit_cnt !== BITCNT_W'(3)) begin
            @(negedge base_clk);
            k++;
        end
        check("abort_pre_cnt", bit_cnt, 3);
        dec_en = 1'b0;
        @(negedge base_clk);
        check("abort_cnt", bit_cnt, 0);
        check("abort_err", fm0_err, 0);
        check("abort_bits_left", exp_bits.size(), 0);
        exp_bits.delete();
        prev_bltc = 10;
        run_frame("after_abort", 10, 8, 8, 64'h5C, 1'b1);

        for (int r = 0; r < 40; r++) begin
            half = int'($urandom_range(4, 20));
            flen = int'($urandom_range(0, 12));
            mode = int'($urandom_range(0, 3));
            if (mode == 2 && flen > 0) nbits = int'($urandom_range(0, flen - 1));
            else if (mode == 3) nbits = flen + int'($urandom_range(1, 3));
            else nbits = flen;
            run_frame("random", half, flen, nbits, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

`ifdef FM0_CRC16_EN
        crc_frame("crc_good", 16'h0000, 16'h0000, 1'b1);
        crc_frame("crc_flip", 16'h0100, 16'h0000, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/fm0_sync_decoder.md
Name: fm0_sync_decoder

Overview:
Parametrised, fully synchronous successor to the gated-clock FM0 backscatter decoder in the reader baseband. Oversamples tag_data on base_clk and self-calibrates the half-symbol period from the first symbol. Decodes FM0 into a bit stream with a per-bit valid strobe, and takes a run-time frame length instead of hard-wired command decoding. Flags coding violations and timeouts, and sits between the analogue slicer and the frame/CRC parser.

Parameters:
CNT_W, 8, width of interval counter and half-period register
BITCNT_W, 7, width of bit counter and frame_len
MIN_HALF, 4, smallest legal calibrated half period in base_clk cycles
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
base_clk  in  1  sample clock
rst_n  in  1  async active-low reset
dec_en  in  1  level; 1 = decode, 0 = abort and return to IDLE
tag_data  in  1  raw sliced tag signal, asynchronous
frame_len  in  BITCNT_W  bits expected after calibration symbol; sampled on leaving IDLE
fm0_start  out  1  one-cycle pulse on first detected edge
fm0_data  out  1  decoded bit, valid with fm0_valid
fm0_valid  out  1  one-cycle strobe per decoded bit
fm0_bltc  out  CNT_W  calibrated half period
fm0_done  out  1  one-cycle pulse, frame complete
fm0_err  out  1  sticky error until dec_en low or reset
bit_cnt  out  BITCNT_W  bits delivered so far

Behaviour:
- Interface: one clock, base_clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0; fm0_bltc = 0; state IDLE.
- Input path:
  - tag_data passes through SYNC_STAGES flops.
  - Edge = XOR of the last two synchronised samples.
  - Adds SYNC_STAGES+1 cycles of latency.
- ivl counter: clears to 1 on each edge and otherwise increments, saturating at all-ones.
- pivot = half + half>>1; limit = 2*half + half>>1. Both are computed CNT_W+1 wide; overflow beyond CNT_W saturates the comparison.
- States:
  - IDLE: wait for dec_en=1 and an edge. Then pulse fm0_start, latch frame_len, go to CAL.
  - CAL: the next edge sets half = ivl, and the first symbol is taken as data-0 (its first half). If half < MIN_HALF, go to ERR. Otherwise go to MID (expect the second half of the calibration symbol).
  - MID: edge with ivl < pivot ends the calibration symbol, go to DATA. Edge with ivl >= pivot, or ivl > limit, goes to ERR.
  - DATA: edge with ivl >= pivot and ivl <= limit emits bit 1, stays in DATA. Edge with ivl < pivot goes to HALF0. No edge and ivl > limit: go to DONE if bit_cnt == frame_len, else ERR.
  - HALF0: edge with ivl < pivot emits bit 0, back to DATA. Edge with ivl >= pivot is a violation, go to ERR. ivl > limit goes to ERR.
  - DONE: fm0_done pulses for one cycle, then go to IDLE-locked: wait for dec_en low before re-arming.
  - ERR: fm0_err=1, no further strobes. Held until dec_en low.
- Output timing: fm0_valid/fm0_data are registered one cycle after the deciding edge. bit_cnt increments in the same cycle.
- Bit overflow: a bit arriving when bit_cnt == frame_len forces ERR, and no valid strobe is issued for that bit.
- frame_len = 0: DONE follows the calibration symbol plus timeout.
- dec_en low in any state: synchronous return to IDLE next cycle. Clears bit_cnt, err, done. Keeps fm0_bltc.
- Simultaneous edge and timeout in the same cycle: the edge wins.

Optional Feature:
FM0_CRC16_EN: adds output crc_ok (1 bit).
- CRC-16/CCITT (poly 0x1021, preset 0xFFFF) is updated on every fm0_valid.
- crc_ok is registered with fm0_done and is 1 if the residue equals 0x1D0F.
- crc_ok clears with dec_en low.
- Without the macro there is no crc_ok port and no CRC logic.

Decomposition:
- Package fm0_pkg: state enum (IDLE, CAL, MID, DATA, HALF0, DONE, ERR) and CRC polynomial, preset and residue constants.
- One sub-module: fm0_edge_sync, containing the synchroniser, edge detect and ivl counter.

Test Plan:
- half=10 cycles, frame_len=8, bits 10110010, then idle -> fm0_bltc=10; eight strobes with data 1,0,1,1,0,0,1,0; bit_cnt=8; fm0_done one cycle at ~26 cycles after last edge; fm0_err=0.
- Violation: in DATA, a short interval (6) then a long one (18) -> fm0_err=1 on the long edge; no strobe for that symbol.
- Calibration too fast: first interval 3 with MIN_HALF=4 -> ERR; no fm0_valid ever.
- Truncated frame: frame_len=8, only 5 bits then silence -> fm0_err=1 after timeout; bit_cnt=5; fm0_done never pulses.
- Abort: dec_en low mid-frame at bit 3 -> next cycle IDLE, bit_cnt=0; re-run with dec_en high decodes a fresh frame correctly.
- FM0_CRC16_EN: 16-bit payload 0x0000 followed by its correct CRC -> crc_ok=1; same with one payload bit flipped -> crc_ok=0.
